// File: rtl/rand_req_sched.sv
// Arbitrated, seedable 8-bit LFSR random source shared by three requesters
// (odd, even, one-hot). Each grant advances the LFSR by exactly one step.
module rand_req_sched #(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] req,
  output logic [2:0] gnt,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_data,
  output logic [1:0] rsp_kind,
  input  logic       seed_load,
  input  logic [7:0] seed_val,
  output logic       busy
);

  if (SEED == 8'h00) begin : g_seed_check
    $error("rand_req_sched: SEED must be nonzero");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GEN  = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [1:0] KIND_ODD  = 2'd0;
  localparam logic [1:0] KIND_EVEN = 2'd1;

  state_t     state_q, state_d;
  logic [7:0] lfsr_q, lfsr_d, lfsr_next;
  logic [1:0] ptr_q, ptr_d;
  logic [2:0] gnt_q, gnt_d;
  logic [1:0] kind_q, kind_d;
  logic [7:0] data_q, data_d;
  logic       valid_q, valid_d;

  logic [1:0] win_idx;
  logic       win_found;
  logic [1:0] cand;

  // Fibonacci LFSR, x^8+x^6+x^5+x^4+1.
  assign lfsr_next = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

  function automatic logic [7:0] shape(input logic [7:0] v, input logic [1:0] kind);
    case (kind)
      KIND_ODD:  return v | 8'h01;
      KIND_EVEN: return v & 8'hFE;
      default:   return 8'h01 << v[2:0];
    endcase
  endfunction

  // Round-robin search starting one past the last serviced requester.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path
    // leaves a variable unassigned and no latch is inferred.
    win_found = 1'b0;
    win_idx   = 2'd0;
    cand      = 2'd0;
    for (int i = 0; i < 3; i++) begin
      cand = 2'((int'(ptr_q) + 1 + i) % 3);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    kind_d  = kind_q;
    data_d  = data_q;
    valid_d = valid_q;

    case (state_q)
      IDLE: begin
        // A seed load takes the cycle; any pending request waits one more.
        if (seed_load) begin
          lfsr_d = (seed_val == 8'h00) ? SEED : seed_val;
        end else if (win_found) begin
          gnt_d   = 3'b001 << win_idx;
          kind_d  = win_idx;
          state_d = GEN;
        end
      end
      GEN: begin
        lfsr_d  = lfsr_next;
        data_d  = shape(lfsr_next, kind_q);
        valid_d = 1'b1;
        state_d = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          valid_d = 1'b0;
          gnt_d   = 3'b000;
          ptr_d   = kind_q;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
        gnt_d   = 3'b000;
      end
    endcase
  end

  // NOTE: sequential state is updated with non-blocking assignments so all
  // registers sample pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      lfsr_q  <= SEED;
      ptr_q   <= 2'd2;
      gnt_q   <= 3'b000;
      kind_q  <= 2'd0;
      data_q  <= 8'h00;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      kind_q  <= kind_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign gnt       = gnt_q;
  assign rsp_valid = valid_q;
  assign rsp_data  = data_q;
  assign rsp_kind  = kind_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_rand_req_sched.sv
// Scoreboard bench for rand_req_sched: a driver pushes expected responses
// from a reference model, a monitor compares them at each response.
module tb_rand_req_sched;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] req;
  logic [2:0] gnt;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;
  logic [1:0] rsp_kind;
  logic       seed_load;
  logic [7:0] seed_val;
  logic       busy;

  localparam logic [7:0] SEED = 8'hA5;

  rand_req_sched #(.SEED(SEED)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .gnt       (gnt),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_kind  (rsp_kind),
    .seed_load (seed_load),
    .seed_val  (seed_val),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] gnt;
    logic [1:0] kind;
    logic [7:0] data;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model state: current LFSR word and last serviced requester.
  logic [7:0] m_lfsr;
  int         m_ptr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] m_step(input logic [7:0] q);
    return {q[6:0], ^(q & 8'hB8)};
  endfunction

  function automatic int m_pick(input logic [2:0] r, input int p);
    for (int k = 1; k <= 3; k++) begin
      int i;
      i = (p + k) % 3;
      if (r[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [7:0] m_shape(input logic [7:0] v, input int kind);
    logic [7:0] one = 8'h01;
    if (kind == 0) return v | 8'h01;
    if (kind == 1) return v & 8'hFE;
    return one << v[2:0];
  endfunction

  // Monitor: sample just before the rising edge, compare every valid cycle
  // (stability during stalls) and retire the entry on the handshake.
  initial begin
    forever begin
      @(negedge clk);
      #3;
      if (rst_n && rsp_valid) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_rsp actual=%0h expected=none t=%0t", rsp_data, $time);
        end else begin
          check("rsp_data", 32'(rsp_data), 32'(sb[0].data));
          check("rsp_kind", 32'(rsp_kind), 32'(sb[0].kind));
          check("rsp_gnt",  32'(gnt),      32'(sb[0].gnt));
          check("rsp_busy", 32'(busy),     32'd1);
          if (rsp_ready) void'(sb.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req = 3'b000;
    rsp_ready = 1'b0;
    seed_load = 1'b0;
    seed_val = 8'h00;
    sb.delete();
    m_lfsr = SEED;
    m_ptr = 2;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One service, starting at a falling edge with the DUT idle.
  task automatic serve(input logic [2:0] pat, input int stall, input bit noise,
                       input bit keep, input int exp_data);
    int   w;
    exp_t e;
    w = m_pick(pat, m_ptr);
    m_ptr = w;
    m_lfsr = m_step(m_lfsr);
    e.gnt = 3'(1 << w);
    e.kind = 2'(w);
    e.data = (exp_data >= 0) ? 8'(exp_data) : m_shape(m_lfsr, w);
    sb.push_back(e);

    req = pat;
    rsp_ready = (stall == 0);
    @(posedge clk);
    #1;
    check("grant_edge_gnt",   32'(gnt),       32'(e.gnt));
    check("grant_edge_valid", 32'(rsp_valid), 32'd0);
    check("grant_edge_busy",  32'(busy),      32'd1);
    @(negedge clk);
    if (noise) begin
      req = 3'($urandom);
      seed_load = 1'b1;
      seed_val = 8'($urandom);
    end
    @(posedge clk);
    #1;
    check("gen_edge_valid", 32'(rsp_valid), 32'd1);
    for (int c = 0; c <= stall; c++) begin
      @(negedge clk);
      if (noise) begin
        req = 3'($urandom);
        seed_val = 8'($urandom);
      end
      rsp_ready = (c == stall);
      @(posedge clk);
    end
    #1;
    check("post_hs_valid", 32'(rsp_valid), 32'd0);
    check("post_hs_gnt",   32'(gnt),       32'd0);
    check("post_hs_sb",    32'(sb.size()), 32'd0);
    @(negedge clk);
    seed_load = 1'b0;
    req = keep ? pat : 3'b000;
  endtask

  task automatic idle_seed(input logic [7:0] val, input logic [2:0] r);
    seed_load = 1'b1;
    seed_val = val;
    req = r;
    @(posedge clk);
    #1;
    check("seed_no_gnt",  32'(gnt),  32'd0);
    check("seed_no_busy", 32'(busy), 32'd0);
    m_lfsr = (val == 8'h00) ? SEED : val;
    @(negedge clk);
    seed_load = 1'b0;
    req = 3'b000;
  endtask

  initial begin
    rst_n = 1'b0;
    req = 3'b000;
    rsp_ready = 1'b0;
    seed_load = 1'b0;
    seed_val = 8'h00;
    m_lfsr = SEED;
    m_ptr = 2;
    #12;
    check("rst_gnt",   32'(gnt),       32'd0);
    check("rst_valid", 32'(rsp_valid), 32'd0);
    check("rst_data",  32'(rsp_data),  32'd0);
    check("rst_kind",  32'(rsp_kind),  32'd0);
    check("rst_busy",  32'(busy),      32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single odd request: first value after SEED.
    serve(3'b001, 0, 1'b0, 1'b0, 8'h4B);

    // All three held: round-robin 001, 010, 100, then back to 001.
    do_reset();
    serve(3'b111, 0, 1'b0, 1'b1, 8'h4B);
    serve(3'b111, 0, 1'b0, 1'b1, 8'h94);
    serve(3'b111, 0, 1'b0, 1'b1, 8'h04);
    serve(3'b111, 0, 1'b0, 1'b0, -1);

    // One-hot request stalled for five cycles.
    serve(3'b100, 5, 1'b0, 1'b0, -1);

    // Zero seed falls back to SEED; seed_load during RESP is ignored.
    idle_seed(8'h00, 3'b000);
    serve(3'b001, 0, 1'b0, 1'b0, 8'h4B);
    serve(3'b001, 2, 1'b1, 1'b0, 8'h95);

    // Seed load wins over a simultaneous request.
    seed_load = 1'b1;
    seed_val = 8'h01;
    req = 3'b001;
    @(posedge clk);
    #1;
    check("seed_req_no_gnt", 32'(gnt), 32'd0);
    @(negedge clk);
    seed_load = 1'b0;
    m_lfsr = 8'h01;
    serve(3'b001, 0, 1'b0, 1'b0, 8'h03);

    // Asynchronous reset while a response is pending.
    req = 3'b001;
    rsp_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    req = 3'b000;
    @(posedge clk);
    #1;
    check("pre_rst_valid", 32'(rsp_valid), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(rsp_valid), 32'd0);
    check("async_rst_gnt",   32'(gnt),       32'd0);
    check("async_rst_busy",  32'(busy),      32'd0);
    sb.delete();
    m_lfsr = SEED;
    m_ptr = 2;
    @(negedge clk);
    rst_n = 1'b1;
    serve(3'b001, 0, 1'b0, 1'b0, 8'h4B);

    // Randomized traffic against the model.
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 3) == 0) idle_seed(8'($urandom), 3'($urandom));
      if ($urandom_range(0, 3) == 0) begin
        req = 3'b000;
        @(negedge clk);
        check("gap_busy", 32'(busy), 32'd0);
      end
      serve(3'($urandom_range(1, 7)), int'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1);
    end
    req = 3'b000;
    repeat (2) @(negedge clk);
    check("final_sb_empty", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rand_req_sched.md
Name: rand_req_sched

Overview:
- Shares one 8-bit LFSR random source between three requesters: odd, even and one-hot number consumers.
- Round-robin arbiter plus 3-state sequencer. The winner is granted, the LFSR advances exactly one step, and the shaped value is returned over a valid/ready response port.
- Sits between the stimulus/test-generation logic and the random datapath, replacing free-running $random use with a deterministic, seedable, arbitrated source.

Parameters:
- SEED, 8'hA5, LFSR reset/fallback seed; must be nonzero (a zero SEED is an elaboration error).

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- req  input  3  level requests: bit0=odd, bit1=even, bit2=onehot
- gnt  output  3  one-hot grant, held from GEN through response handshake
- rsp_valid  output  1  response data valid
- rsp_ready  input  1  consumer accepts response
- rsp_data  output  8  shaped random value
- rsp_kind  output  2  kind of rsp_data: 0=odd, 1=even, 2=onehot
- seed_load  input  1  load seed_val into LFSR (honoured in IDLE only)
- seed_val  input  8  new seed
- busy  output  1  high in GEN and RESP

Behaviour:
- Reset (async, rst_n=0):
  - State=IDLE; gnt=0, rsp_valid=0, rsp_data=0, rsp_kind=0, busy=0.
  - lfsr=SEED; last-grant pointer=2, so req0 has first priority.
- LFSR:
  - Fibonacci, polynomial x^8+x^6+x^5+x^4+1.
  - fb = q[7]^q[5]^q[4]^q[3]; next = {q[6:0], fb}.
  - Advances only on the GEN cycle, never in IDLE or RESP.
- Shaping, where v = next LFSR value:
  - odd: v | 8'h01
  - even: v & 8'hFE
  - onehot: 8'h01 << v[2:0]
- State IDLE:
  - If seed_load=1: lfsr <= (seed_val==0) ? SEED : seed_val. No grant this cycle, even if req!=0; seed_load has priority.
  - Else if req!=0: pick the first set bit searching from pointer+1 upward (mod 3). gnt <= winner, rsp_kind <= winner index, state <= GEN.
  - Else stay in IDLE.
- State GEN:
  - lfsr <= next; rsp_data <= shape(next, kind); rsp_valid <= 1; state <= RESP.
- State RESP:
  - rsp_data, rsp_kind and gnt are held stable while rsp_valid=1 and rsp_ready=0. No timeout.
  - On the rsp_valid & rsp_ready edge: rsp_valid <= 0, gnt <= 0, pointer <= winner index, state <= IDLE.
- Latency:
  - req seen in IDLE at edge k, gnt high after k, rsp_valid high after k+1.
  - Minimum 3 cycles per service with rsp_ready tied high.
- Arbitration boundaries:
  - A request dropped after grant does not abort service; the response is still produced.
  - req changes during GEN/RESP are ignored until return to IDLE.
  - A requester still holding req after its handshake competes again in round-robin; it is never served twice while another bit is pending.
  - seed_load outside IDLE is ignored.
- Reset mid-operation: any pending response is discarded immediately, outputs return to reset values, and the LFSR returns to SEED.
- No combinational path from req or rsp_ready to any output; all outputs are registered.

Test Plan:
- Reset, then req=3'b001 pulsed one cycle, rsp_ready=1 -> gnt=001 for 2 cycles; rsp_valid for 1 cycle with rsp_data=8'h4B, rsp_kind=0; lfsr=8'h4A.
- Reset, then req=3'b111 held, rsp_ready=1 -> grant order 001, 010, 100. Responses: 8'h4B (odd of 4A), 8'h94 (even of 95), 8'h04 (onehot of 2A, v[2:0]=2). The 4th grant returns to 001.
- Single req2 with rsp_ready=0 for 5 cycles after rsp_valid rises -> rsp_data, rsp_kind, gnt and busy are stable all 5 cycles; the LFSR does not advance. The handshake on cycle 6 returns to IDLE.
- seed_load=1 with seed_val=8'h00 in IDLE, then req0 -> LFSR reloaded to SEED; response 8'h4B. seed_load asserted during RESP -> ignored; the next response continues the sequence (odd of 8'h95 = 8'h95).
- seed_load=1 with seed_val=8'h01 and req=001 in the same cycle -> no grant that cycle; next cycle grant; response is odd of 8'h02 = 8'h03.
- rst_n pulsed low while in RESP with rsp_valid=1 -> rsp_valid, gnt and busy drop asynchronously (before the next clk edge). After release, req0 yields 8'h4B again.
